// File: rtl/network_mac_pkg.sv
// Shared widths, sideband beat descriptor and the output reduction helper
// for the pipelined multiply-accumulate unit.
package network_mac_pkg;

  localparam int unsigned DEF_DIN0_WIDTH = 12;
  localparam int unsigned DEF_DIN1_WIDTH = 16;
  localparam int unsigned DEF_ACC_WIDTH  = 40;
  localparam int unsigned DEF_DOUT_WIDTH = 28;
  localparam int unsigned PROD_WIDTH     = DEF_DIN0_WIDTH + DEF_DIN1_WIDTH;
  localparam int unsigned RED_WIDTH      = 64;

  typedef struct packed {
    logic mode;
    logic first;
    logic last;
    logic valid;
  } sband_t;

  typedef struct packed {
    logic                        ovf;
    logic signed [RED_WIDTH-1:0] dout;
  } red_t;

  // Works on a sign-extended 64-bit value so one helper serves any DOUT width.
  function automatic red_t sat_trunc(input logic signed [RED_WIDTH-1:0] acc,
                                     input int unsigned dout_w,
                                     input logic saturate);
    red_t res;
    logic signed [RED_WIDTH-1:0] one, hi, lo, wrapped;
    one     = 1;
    hi      = (one <<< (dout_w - 1)) - one;
    lo      = -(one <<< (dout_w - 1));
    wrapped = (acc <<< (RED_WIDTH - dout_w)) >>> (RED_WIDTH - dout_w);
    res.ovf = (acc > hi) || (acc < lo);
    if (saturate && res.ovf) res.dout = acc[RED_WIDTH-1] ? lo : hi;
    else                     res.dout = wrapped;
    return res;
  endfunction

endpackage

// File: rtl/network_mac_pipe_if.sv
// Beat-in / result-out handshake bundle of the multiply-accumulate unit.
interface network_mac_pipe_if
  import network_mac_pkg::*;
#(
  parameter int unsigned DIN0_WIDTH = DEF_DIN0_WIDTH,
  parameter int unsigned DIN1_WIDTH = DEF_DIN1_WIDTH,
  parameter int unsigned DOUT_WIDTH = DEF_DOUT_WIDTH
);
  logic                         in_valid;
  logic                         in_ready;
  logic signed [DIN0_WIDTH-1:0] din0;
  logic signed [DIN1_WIDTH-1:0] din1;
  logic                         in_mode;
  logic                         in_first;
  logic                         in_last;
  logic                         out_valid;
  logic                         out_ready;
  logic signed [DOUT_WIDTH-1:0] dout;
  logic                         dout_ovf;

  modport master (output in_valid, din0, din1, in_mode, in_first, in_last, out_ready,
                  input  in_ready, out_valid, dout, dout_ovf);
  modport slave  (input  in_valid, din0, din1, in_mode, in_first, in_last, out_ready,
                  output in_ready, out_valid, dout, dout_ovf);
endinterface

// File: rtl/network_mac_mul_pipe.sv
// MUL_STAGES-deep signed multiplier with a shared enable; input, product and
// post-product registers are kept reset-free so they can fold into a DSP slice.
module network_mac_mul_pipe
  import network_mac_pkg::*;
#(
  parameter int unsigned DIN0_WIDTH = DEF_DIN0_WIDTH,
  parameter int unsigned DIN1_WIDTH = DEF_DIN1_WIDTH,
  parameter int unsigned MUL_STAGES = 2
) (
  input  logic                                    clk,
  input  logic                                    en,
  input  logic signed [DIN0_WIDTH-1:0]            a,
  input  logic signed [DIN1_WIDTH-1:0]            b,
  output logic signed [DIN0_WIDTH+DIN1_WIDTH-1:0] p
);
  localparam int unsigned PW = DIN0_WIDTH + DIN1_WIDTH;

  if (MUL_STAGES == 1) begin : g_single
    logic signed [PW-1:0] p_q, p_d;

    always_comb p_d = en ? PW'(a) * PW'(b) : p_q;
    always_ff @(posedge clk) p_q <= p_d;
    assign p = p_q;
  end else begin : g_multi
    localparam int unsigned NS = MUL_STAGES - 1;
    logic signed [DIN0_WIDTH-1:0] a_q, a_d;
    logic signed [DIN1_WIDTH-1:0] b_q, b_d;
    // Product stages packed newest-at-bottom; oldest slice feeds p.
    logic [NS*PW-1:0] m_q, m_d;

    always_comb begin
      a_d = a_q;
      b_d = b_q;
      m_d = m_q;
      if (en) begin
        a_d = a;
        b_d = b;
        m_d = (NS*PW)'({m_q, PW'(a_q) * PW'(b_q)});
      end
    end

    always_ff @(posedge clk) begin
      a_q <= a_d;
      b_q <= b_d;
      m_q <= m_d;
    end

    assign p = m_q[NS*PW-1 -: PW];
  end
endmodule

// File: rtl/network_mac_pipe.sv
// Pipelined signed MAC: registered multiplier, sideband shift register,
// accumulator with first/last framing, saturate/truncate reduction and output register.
module network_mac_pipe
  import network_mac_pkg::*;
#(
  parameter int unsigned DIN0_WIDTH = DEF_DIN0_WIDTH,
  parameter int unsigned DIN1_WIDTH = DEF_DIN1_WIDTH,
  parameter int unsigned ACC_WIDTH  = DEF_ACC_WIDTH,
  parameter int unsigned DOUT_WIDTH = DEF_DOUT_WIDTH,
  parameter int unsigned MUL_STAGES = 2,
  parameter int unsigned SATURATE   = 1
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  network_mac_pipe_if.slave bus
);
  localparam int unsigned PROD_W = DIN0_WIDTH + DIN1_WIDTH;
  localparam int unsigned SB_W   = $bits(sband_t);

  logic                         adv;
  logic signed [PROD_W-1:0]     prod;
  sband_t [MUL_STAGES-1:0]      sb_q, sb_d;
  sband_t                       sb_in, sb_out;
  logic signed [ACC_WIDTH-1:0]  acc_q, acc_d, p_ext, sum, r;
  logic                         res_vld;
  red_t                         red;
  logic                         out_valid_q, out_valid_d;
  logic                         ovf_q, ovf_d;
  logic signed [DOUT_WIDTH-1:0] dout_q, dout_d;

  // Single global advance: every stage holds together, no bubble collapse.
  assign adv          = !out_valid_q || bus.out_ready;
  assign bus.in_ready = adv;

  network_mac_mul_pipe #(
    .DIN0_WIDTH (DIN0_WIDTH),
    .DIN1_WIDTH (DIN1_WIDTH),
    .MUL_STAGES (MUL_STAGES)
  ) u_mul (
    .clk (ap_clk),
    .en  (adv),
    .a   (bus.din0),
    .b   (bus.din1),
    .p   (prod)
  );

  always_comb begin
    sb_in.mode  = bus.in_mode;
    sb_in.first = bus.in_first;
    sb_in.last  = bus.in_last;
    sb_in.valid = bus.in_valid;
    sb_d = sb_q;
    if (adv) sb_d = (MUL_STAGES*SB_W)'({sb_q, sb_in});
    sb_out = sb_q[MUL_STAGES-1];

    p_ext   = ACC_WIDTH'(prod);
    sum     = sb_out.first ? p_ext : acc_q + p_ext;
    acc_d   = acc_q;
    r       = p_ext;
    res_vld = 1'b0;
    if (adv && sb_out.valid) begin
      if (sb_out.mode) begin
        acc_d   = sum;
        r       = sum;
        res_vld = sb_out.last;
      end else begin
        res_vld = 1'b1;
      end
    end

    red         = sat_trunc(RED_WIDTH'(r), DOUT_WIDTH, SATURATE != 0);
    out_valid_d = adv ? res_vld : out_valid_q;
    dout_d      = dout_q;
    ovf_d       = ovf_q;
    if (res_vld) begin
      dout_d = DOUT_WIDTH'(red.dout);
      ovf_d  = red.ovf;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      sb_q        <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      dout_q      <= '0;
      ovf_q       <= 1'b0;
    end else begin
      sb_q        <= sb_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      dout_q      <= dout_d;
      ovf_q       <= ovf_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.dout      = dout_q;
  assign bus.dout_ovf  = ovf_q;
endmodule

// File: tb/tb_network_mac_pipe.sv
// Directed bench for network_mac_pipe: hand-computed results checked with immediate assertions.
module tb_network_mac_pipe;

  logic ap_clk = 1'b0;
  logic ap_rst_n;
  int   checks = 0;
  int   fails  = 0;

  logic signed [63:0] got_d[$];
  logic               got_o[$];

  always #5 ap_clk = ~ap_clk;

  network_mac_pipe_if #(.DIN0_WIDTH(12), .DIN1_WIDTH(16), .DOUT_WIDTH(28)) bus ();

  network_mac_pipe #(
    .DIN0_WIDTH (12),
    .DIN1_WIDTH (16),
    .ACC_WIDTH  (40),
    .DOUT_WIDTH (28),
    .MUL_STAGES (2),
    .SATURATE   (1)
  ) dut (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .bus      (bus)
  );

  // Result collector: inputs change only just after posedge, so the negedge
  // sample is what the next rising edge will transfer.
  always @(negedge ap_clk) begin
    if (ap_rst_n && bus.out_valid && bus.out_ready) begin
      got_d.push_back(bus.dout);
      got_o.push_back(bus.dout_ovf);
    end
  end

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic signed [63:0] dat_at(input int i);
    if (i < got_d.size()) return got_d[i];
    return 'x;
  endfunction

  function automatic logic ovf_at(input int i);
    if (i < got_o.size()) return got_o[i];
    return 1'bx;
  endfunction

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic send(input logic m, input logic f, input logic l, input int a, input int b);
    int unsigned cyc = 0;
    bus.in_valid = 1'b1;
    bus.in_mode  = m;
    bus.in_first = f;
    bus.in_last  = l;
    bus.din0     = 12'(a);
    bus.din1     = 16'(b);
    @(negedge ap_clk);
    while (!bus.in_ready && cyc < 50) begin
      @(negedge ap_clk);
      cyc++;
    end
    if (cyc >= 50) check("send_timeout", 64'(cyc), 0);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(input int n);
    int unsigned cyc = 0;
    while (got_d.size() < n && cyc < 50) begin
      tick();
      cyc++;
    end
    check("out_timeout", 64'(got_d.size() >= n), 1);
    repeat (5) @(posedge ap_clk);
    #1;
  endtask

  task automatic flush();
    got_d.delete();
    got_o.delete();
  endtask

  int                 a4[8]   = '{1, -2, 3, -4, 5, -6, 7, -8};
  int                 exp4[8] = '{1000, -2000, 3000, -4000, 5000, -6000, 7000, -8000};
  int                 k;
  logic               stall_prev;
  logic signed [63:0] held;

  initial begin
    ap_rst_n      = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_mode   = 1'b0;
    bus.in_first  = 1'b0;
    bus.in_last   = 1'b0;
    bus.din0      = '0;
    bus.din1      = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge ap_clk);
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_dout", bus.dout, 0);
    check("rst_ovf", bus.dout_ovf, 0);
    ap_rst_n = 1'b1;
    tick();
    check("rst_in_ready", bus.in_ready, 1);

    // 1: mode 0 pass-through, latency 3
    flush();
    send(1'b0, 1'b0, 1'b0, -2048, 32767);
    check("t1_lat0", bus.out_valid, 0);
    tick();
    check("t1_lat1", bus.out_valid, 0);
    tick();
    check("t1_lat2", bus.out_valid, 1);
    check("t1_dout", bus.dout, -67106816);
    check("t1_ovf", bus.dout_ovf, 0);
    wait_out(1);

    // 2: three-term sum saturates
    flush();
    send(1'b1, 1'b1, 1'b0, -2048, 32767);
    send(1'b1, 1'b0, 1'b0, -2048, 32767);
    send(1'b1, 1'b0, 1'b1, -2048, 32767);
    wait_out(1);
    check("t2_count", 64'(got_d.size()), 1);
    check("t2_dout", dat_at(0), -134217728);
    check("t2_ovf", ovf_at(0), 1);

    // 3: mode-0 beat interleaved inside a sum
    flush();
    send(1'b1, 1'b1, 1'b0, 3, 4);
    send(1'b1, 1'b0, 1'b0, 5, -6);
    send(1'b0, 1'b0, 1'b0, 10, 10);
    send(1'b1, 1'b0, 1'b1, 7, 2);
    wait_out(2);
    check("t3_count", 64'(got_d.size()), 2);
    check("t3_first", dat_at(0), 100);
    check("t3_second", dat_at(1), -4);
    check("t3_ovf", ovf_at(1), 0);

    // 4: back-to-back stream with a downstream stall
    flush();
    k = 0;
    stall_prev = 1'b0;
    held = '0;
    for (int c = 0; c < 40; c++) begin
      bus.out_ready = !(c >= 4 && c <= 7);
      bus.in_mode   = 1'b0;
      bus.in_first  = 1'b0;
      bus.in_last   = 1'b0;
      if (k < 8) begin
        bus.in_valid = 1'b1;
        bus.din0     = 12'(a4[k]);
        bus.din1     = 16'd1000;
      end else begin
        bus.in_valid = 1'b0;
      end
      @(negedge ap_clk);
      if (c >= 4 && c <= 7) check("t4_in_ready_stall", bus.in_ready, 0);
      if (stall_prev) check("t4_dout_hold", bus.dout, held);
      stall_prev = bus.out_valid && !bus.out_ready;
      held = bus.dout;
      if (bus.in_valid && bus.in_ready) k++;
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    check("t4_accepted", 64'(k), 8);
    check("t4_count", 64'(got_d.size()), 8);
    for (int i = 0; i < 8; i++) check($sformatf("t4_res%0d", i), dat_at(i), 64'(exp4[i]));

    // 5: single-term sum, then an unpolluted new sum
    flush();
    send(1'b1, 1'b1, 1'b1, 127, -1);
    send(1'b1, 1'b1, 1'b0, 2, 3);
    send(1'b1, 1'b0, 1'b1, 4, 5);
    wait_out(2);
    check("t5_count", 64'(got_d.size()), 2);
    check("t5_single", dat_at(0), -127);
    check("t5_next", dat_at(1), 26);

    // 6: reset with beats in flight
    flush();
    send(1'b0, 1'b0, 1'b0, 5, 5);
    send(1'b1, 1'b1, 1'b0, 1000, 1000);
    send(1'b1, 1'b0, 1'b0, 1000, 1000);
    check("t6_pre_valid", bus.out_valid, 1);
    ap_rst_n = 1'b0;
    #1;
    check("t6_rst_valid", bus.out_valid, 0);
    check("t6_rst_dout", bus.dout, 0);
    repeat (2) @(posedge ap_clk);
    #1;
    ap_rst_n = 1'b1;
    tick();
    send(1'b1, 1'b0, 1'b1, 2, 2);
    send(1'b1, 1'b1, 1'b0, 7, 8);
    send(1'b1, 1'b0, 1'b1, -3, 4);
    wait_out(2);
    check("t6_count", 64'(got_d.size()), 2);
    check("t6_acc_cleared", dat_at(0), 4);
    check("t6_fresh_sum", dat_at(1), 44);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
